hazard_scoreboard: RTL
======================

// Module: hazard_scoreboard
// PURPOSE
//  Producer-side companion to the EX-stage forwarding mux: tracks in-flight destination registers and when
//  each result first reaches the EX/MEM forward path. Sits at ID->EX issue; raises stall while an ID
//  source (or WAW rd) is not yet forwardable. Covers load-use and multi-cycle (mul/div) hazards.
// PARAMETERS
//  NUM_REGS  32  architectural registers; x0 never tracked
//  LAT_W     3   latency counter width; max issue latency 2**LAT_W-1 = 7 cycles
// PORTS
//  clk           in   1         clock, rising edge
//  rst           in   1         synchronous reset, active-high
//  id_valid      in   1         valid instruction in ID requesting issue
//  id_rs1        in   5         ID source 1
//  id_rs2        in   5         ID source 2
//  id_uses_rs1   in   1         ID reads rs1
//  id_uses_rs2   in   1         ID reads rs2
//  id_rd         in   5         ID destination
//  id_RegWrite   in   1         ID writes rd
//  id_latency    in   LAT_W     extra cycles until result is forwardable (ALU 0, load 1, mul 3)
//  id_flush      in   1         kill ID instruction this cycle (no issue)
//  ex_flush      in   1         kill instruction issued last cycle (now in EX)
//  stall         out  1         hold PC/IF/ID, bubble into EX (combinational)
//  pending_mask  out  NUM_REGS  bit r = cnt[r]!=0 (registered state)
// BEHAVIOUR
//  - State: cnt[r] (LAT_W bits) for r=1..NUM_REGS-1; last_rd (5b), last_vld (1b).
//  - Reset (rst=1 at edge): all cnt=0, last_vld=0; stall=0, pending_mask=0 from the following cycle.
//  - raw1 = id_uses_rs1 && id_rs1!=0 && cnt[id_rs1]!=0; raw2 likewise for rs2.
//  - waw  = id_RegWrite && id_rd!=0 && cnt[id_rd] > id_latency.
//  - stall = id_valid && !id_flush && (raw1||raw2||waw); same-cycle combinational, no registered latency.
//  - issue = id_valid && !id_flush && !stall.
//  - Each edge, in priority order (lowest first, later overrides):
//    1. every cnt[r]!=0 decrements by 1; cnt never wraps below 0
//    2. ex_flush && last_vld: cnt[last_rd] <= 0
//    3. issue && id_RegWrite && id_rd!=0: cnt[id_rd] <= id_latency
//  - last_vld <= issue && id_RegWrite && id_rd!=0 && id_latency!=0; last_rd <= id_rd.
//  - id_latency=0 writes cnt=0: no tracking (EX/MEM forward covers it).
//  - id_rd=0 or !id_RegWrite: never recorded; source x0 never stalls.
//  - ex_flush with last_vld=0: no effect. ex_flush and id_flush may assert together.
//  - Flush and issue to same rd in one cycle: the new issue value wins.
//  - rst mid-operation drops all pending entries; the caller flushes the pipe together with rst.
// CONFIGURATION
//  - SCOREBOARD_STATS_EN defined: adds output stall_cycles [31:0].
//    - Counts cycles with stall=1; saturates at 32'hFFFF_FFFF; 0 on rst.
//  - Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Shared pipeline_pkg:
//    - typedef reg_idx_t = logic [4:0]
//    - LAT_W
//    - latency constants LAT_ALU=0, LAT_LOAD=1, LAT_MUL=3, LAT_DIV=7
//  - Sub-module scoreboard_entry: one down-counter with clear and load inputs, instantiated per register
//    by a generate loop. Priority, issue logic and stall logic stay in the top.
// TESTING
//  - Load-use: issue lw x5 (lat 1); next cycle ID add x6,x5,x1 -> stall=1 one cycle, then 0; pending_mask[5] 1 for one cycle.
//  - ALU chain: add x3 (lat 0) then sub using x3 -> stall=0, pending_mask stays 0.
//  - Mul: mul x7 (lat 3); consumer waits in ID -> stall 1,1,1 then 0; pending_mask[7] low after 3 cycles.
//  - Flush: lw x9 issued; next cycle ex_flush=1 with consumer of x9 in ID -> stall=1 that cycle, cnt[9]=0 after; next cycle stall=0.
//  - x0 / WAW:
//    - lw x0 -> pending_mask=0, no stall.
//    - div x4 (lat 7) then add x4 (lat 0) -> stall until cnt[4]=0, then issue.
//  - Reset mid-op: mul x7 pending, rst=1 one cycle -> pending_mask=0, stall=0; stall_cycles=0 when SCOREBOARD_STATS_EN is defined.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared pipeline types and issue-latency constants used by the hazard scoreboard and its users.
// No logic; latencies are extra cycles until a result reaches the EX/MEM forward path.
package pipeline_pkg;

  typedef logic [4:0] reg_idx_t;

  localparam int LAT_W = 3;

  localparam logic [LAT_W-1:0] LAT_ALU  = 3'd0;
  localparam logic [LAT_W-1:0] LAT_LOAD = 3'd1;
  localparam logic [LAT_W-1:0] LAT_MUL  = 3'd3;
  localparam logic [LAT_W-1:0] LAT_DIV  = 3'd7;

endpackage

// File: rtl/scoreboard_entry.sv
// One per-register down-counter: load beats clear beats decrement; stops at zero, never wraps.
// State updates on the clock edge; o_cnt/o_busy reflect the registered count, no backpressure.
module scoreboard_entry #(
  parameter int LAT_W = pipeline_pkg::LAT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_ld,
  input  logic [LAT_W-1:0] i_ld_val,
  output logic [LAT_W-1:0] o_cnt,
  output logic             o_busy
);

  logic [LAT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_ld) begin
      r_cnt <= i_ld_val;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID->EX issue scoreboard: stall is combinational from ID fields and registered per-register counts.
// Optional SCOREBOARD_STATS_EN adds a saturating stall_cycles counter.
module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int LAT_W    = pipeline_pkg::LAT_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [4:0]          id_rs1,
  input  logic [4:0]          id_rs2,
  input  logic                id_uses_rs1,
  input  logic                id_uses_rs2,
  input  logic [4:0]          id_rd,
  input  logic                id_RegWrite,
  input  logic [LAT_W-1:0]    id_latency,
  input  logic                id_flush,
  input  logic                ex_flush,
  output logic                stall,
  output logic [NUM_REGS-1:0] pending_mask
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]         stall_cycles
`endif
);

  import pipeline_pkg::*;

  logic [LAT_W-1:0]    w_cnt [NUM_REGS];
  logic [NUM_REGS-1:0] w_busy;
  logic                w_raw1;
  logic                w_raw2;
  logic                w_waw;
  logic                w_issue;
  logic                w_load;
  logic                w_flush;
  reg_idx_t            r_last_rd;
  logic                r_last_vld;

  // x0 is never tracked, so its slot reads as permanently idle.
  assign w_cnt[0]  = '0;
  assign w_busy[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    scoreboard_entry #(.LAT_W(LAT_W)) u_entry (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_flush && (r_last_rd == reg_idx_t'(r))),
      .i_ld     (w_load && (id_rd == reg_idx_t'(r))),
      .i_ld_val (id_latency),
      .o_cnt    (w_cnt[r]),
      .o_busy   (w_busy[r])
    );
  end

  assign w_raw1 = id_uses_rs1 && (id_rs1 != '0) && (w_cnt[id_rs1] != '0);
  assign w_raw2 = id_uses_rs2 && (id_rs2 != '0) && (w_cnt[id_rs2] != '0);
  // A younger writer may issue once the older result lands no later than its own.
  assign w_waw  = id_RegWrite && (id_rd != '0) && (w_cnt[id_rd] > id_latency);

  assign stall   = id_valid && !id_flush && (w_raw1 || w_raw2 || w_waw);
  assign w_issue = id_valid && !id_flush && !stall;
  assign w_load  = w_issue && id_RegWrite && (id_rd != '0);
  assign w_flush = ex_flush && r_last_vld;

  assign pending_mask = w_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_vld <= 1'b0;
      r_last_rd  <= '0;
    end else begin
      r_last_vld <= w_load && (id_latency != '0);
      r_last_rd  <= id_rd;
    end
  end

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (stall && (r_stall_cycles != 32'hFFFF_FFFF)) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule
